gpio_irq: RTL

Parametrised general-purpose I/O peripheral with input, output and bidirectional ports, and edge-triggered input interrupts. Input ports are synchronised; output ports support atomic set and clear writes. The block sits on the peripheral bus beside the timer and UART and drives one level interrupt line into the CPU interrupt controller.

---
 rtl/gpio_irq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/gpio_irq.sv
// GPIO peripheral: synchronised inputs, set/clear outputs, tri-state pads, edge interrupts.
// Define GPIO_IRQ_EN to build the edge-detect, IRQ_EN/IRQ_EDGE/IRQ_STAT registers and irq.
module gpio_irq #(
    parameter int IN_CH  = 8,
    parameter int OUT_CH = 8,
    parameter int IO_CH  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_,
    input  logic [IN_CH-1:0]  gpio_in,
    output logic [OUT_CH-1:0] gpio_out,
    inout  wire  [IO_CH-1:0]  gpio_io,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] IDX_IN    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] IDX_OUT   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_IO    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] IDX_DIR   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] IDX_SET   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] IDX_CLR   = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] IDX_EN    = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] IDX_EDGE  = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] IDX_STAT  = ADDR_W'(8);

    logic              access;
    logic              wr_en;
    logic [IN_CH-1:0]  in_s1, in_s2;
    logic [IO_CH-1:0]  io_s1, io_s2;
    logic [IO_CH-1:0]  io_out, io_dir;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_bits;

    assign access      = ~cs_ & ~as_;
    assign wr_en       = access & ~rw;
    assign unused_bits = ^wr_data;

    for (genvar i = 0; i < IO_CH; i++) begin : g_pad
        assign gpio_io[i] = io_dir[i] ? io_out[i] : 1'bz;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_s1 <= '0;
            in_s2 <= '0;
            io_s1 <= '0;
            io_s2 <= '0;
        end else begin
            in_s1 <= gpio_in;
            in_s2 <= in_s1;
            io_s1 <= gpio_io;
            io_s2 <= io_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out <= '0;
            io_out   <= '0;
            io_dir   <= '0;
        end else if (wr_en) begin
            case (addr)
                IDX_OUT: gpio_out <= wr_data[OUT_CH-1:0];
                IDX_SET: gpio_out <= gpio_out | wr_data[OUT_CH-1:0];
                IDX_CLR: gpio_out <= gpio_out & ~wr_data[OUT_CH-1:0];
                IDX_IO:  io_out   <= wr_data[IO_CH-1:0];
                IDX_DIR: io_dir   <= wr_data[IO_CH-1:0];
                default: ;
            endcase
        end
    end

`ifdef GPIO_IRQ_EN
    logic [IN_CH-1:0] in_prev;
    logic [IN_CH-1:0] irq_en, irq_edge, irq_stat;
    logic [IN_CH-1:0] edge_hit, w1c;

    assign edge_hit = (~irq_edge & ~in_prev & in_s2) | (irq_edge & in_prev & ~in_s2);
    assign w1c      = (wr_en && addr == IDX_STAT) ? wr_data[IN_CH-1:0] : '0;
    assign irq      = |(irq_stat & irq_en);

    // A new edge in the same cycle as a W1C wins, so no event is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_prev  <= '0;
            irq_en   <= '0;
            irq_edge <= '0;
            irq_stat <= '0;
        end else begin
            in_prev  <= in_s2;
            irq_stat <= (irq_stat & ~w1c) | edge_hit;
            if (wr_en && addr == IDX_EN)   irq_en   <= wr_data[IN_CH-1:0];
            if (wr_en && addr == IDX_EDGE) irq_edge <= wr_data[IN_CH-1:0];
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (addr)
            IDX_IN:   rd_mux[IN_CH-1:0]  = in_s2;
            IDX_OUT:  rd_mux[OUT_CH-1:0] = gpio_out;
            IDX_IO:   rd_mux[IO_CH-1:0]  = io_s2;
            IDX_DIR:  rd_mux[IO_CH-1:0]  = io_dir;
`ifdef GPIO_IRQ_EN
            IDX_EN:   rd_mux[IN_CH-1:0]  = irq_en;
            IDX_EDGE: rd_mux[IN_CH-1:0]  = irq_edge;
            IDX_STAT: rd_mux[IN_CH-1:0]  = irq_stat;
`endif
            default:  rd_mux = '0;
        endcase
    end

    // Bus response: one registered cycle per sampled access, data zero on writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
            rdy_    <= 1'b1;
        end else begin
            rdy_    <= ~access;
            rd_data <= (access && rw) ? rd_mux : '0;
        end
    end

endmodule
